// File: rtl/imem_loader_if.sv
// Byte-stream receive and instruction-memory write bus for imem_loader.
// master = loader side, slave = byte source / memory side.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 9
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              im_en;
    logic [ADDR_W-1:0] pc_in;
    logic [31:0]       data_in;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output im_en,
        output pc_in,
        output data_in
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  im_en,
        input  pc_in,
        input  data_in
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory, holding the CPU in reset.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    imem_loader_if.master  bus,
    output logic           cpu_rst_n,
    output logic           busy,
    output logic           done,
    output logic           err
);
    localparam int unsigned IDX_W     = ADDR_W + 1;
    localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [IDX_W-1:0]  len_q, len_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       asm_q, asm_d;
    logic [ADDR_W-1:0] pc_in_q, pc_in_d;
    logic [31:0]       data_in_q, data_in_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rx_ready_q, rx_ready_d;
    logic              im_en_q, im_en_d;
    logic              busy_q, busy_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif
    logic [15:0]       len_full;
    logic              hs_c;

    assign hs_c = bus.rx_valid && rx_ready_q;

    // State and registered outputs; reset beats start and any handshake on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_lo_q    <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            bcnt_q      <= '0;
            asm_q       <= '0;
            pc_in_q     <= '0;
            data_in_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rx_ready_q  <= 1'b0;
            im_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            bcnt_q      <= bcnt_d;
            asm_q       <= asm_d;
            pc_in_q     <= pc_in_d;
            data_in_q   <= data_in_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rx_ready_q  <= rx_ready_d;
            im_en_q     <= im_en_d;
            busy_q      <= busy_d;
            cpu_rst_n_q <= cpu_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        len_lo_d  = len_lo_q;
        len_d     = len_q;
        idx_d     = idx_q;
        bcnt_d    = bcnt_q;
        asm_d     = asm_q;
        pc_in_d   = pc_in_q;
        data_in_d = data_in_q;
        done_d    = done_q;
        err_d     = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d     = chk_q;
`endif
        len_full  = {bus.rx_data, len_lo_q};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LEN_LO;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_LEN_LO: begin
                if (hs_c) begin
                    len_lo_d = bus.rx_data;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (hs_c) begin
                    if (len_full == 16'd0 || 32'(len_full) > MAX_WORDS) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                        len_d   = IDX_W'(len_full);
                        idx_d   = '0;
                        bcnt_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_d   = '0;
`endif
                    end
                end
            end
            S_DATA: begin
                if (hs_c) begin
                    bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d  = chk_q ^ bus.rx_data;
`endif
                    // Bytes 0..2 are staged; byte 3 completes the word straight into data_in.
                    case (bcnt_q)
                        2'd0:    asm_d[7:0]   = bus.rx_data;
                        2'd1:    asm_d[15:8]  = bus.rx_data;
                        2'd2:    asm_d[23:16] = bus.rx_data;
                        default: begin
                            state_d   = S_WRITE;
                            pc_in_d   = idx_q[ADDR_W-1:0];
                            data_in_d = {bus.rx_data, asm_q};
                        end
                    endcase
                end
            end
            S_WRITE: begin
                idx_d = idx_q + IDX_W'(1);
                if (idx_d == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
                    done_d  = 1'b1;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (hs_c) begin
                    state_d = S_DONE;
                    err_d   = (bus.rx_data != chk_q);
                    done_d  = (bus.rx_data == chk_q);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state register.
        rx_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (state_d == S_CHK) rx_ready_d = 1'b1;
`endif
        im_en_d     = (state_d == S_WRITE);
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        cpu_rst_n_d = (state_d == S_DONE) && done_d;
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.im_en    = im_en_q;
    assign bus.pc_in    = pc_in_q;
    assign bus.data_in  = data_in_q;
    assign cpu_rst_n    = cpu_rst_n_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
endmodule
